// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard interface: ID instruction fields in, stall/issue/write-back controls out.
interface hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic [4:0]       id_rd_i;
  logic             id_we_i;
  logic             flush_i;

  logic             stall_o;
  logic             pc_we_o;
  logic             ifid_we_o;
  logic             idex_bubble_o;
  logic             rf_we_o;
  logic [4:0]       rf_wr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_we_i, flush_i,
    input  stall_o, pc_we_o, ifid_we_o, idex_bubble_o, rf_we_o, rf_wr_o,
           stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_we_i, flush_i,
    output stall_o, pc_we_o, ifid_we_o, idex_bubble_o, rf_we_o, rf_wr_o,
           stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall-only RAW scoreboard for the ID stage: tracks in-flight destinations in EX..WB,
// stalls ID on a pending source, and drives the WB register-file write controls.
module hazard_scoreboard #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  slot_t            slots [DEPTH];
  slot_t            slot0_next;
  logic [CNT_W-1:0] stall_cnt;
  logic             match1;
  logic             match2;
  logic             hit1;
  logic             hit2;
  logic             raw;
  logic             stall;

  // Register-number match against every in-flight slot, WB included.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slots[i].valid && (slots[i].rd == sb.id_rs1_i)) match1 = 1'b1;
      if (slots[i].valid && (slots[i].rd == sb.id_rs2_i)) match2 = 1'b1;
    end
  end

  assign hit1  = match1 & sb.id_rs1_used_i & (sb.id_rs1_i != 5'd0);
  assign hit2  = match2 & sb.id_rs2_used_i & (sb.id_rs2_i != 5'd0);
  assign raw   = sb.id_valid_i & (hit1 | hit2);
  // A squashed ID instruction cannot hazard, so flush wins.
  assign stall = raw & ~sb.flush_i;

  always_comb begin
    slot0_next.valid = sb.id_valid_i & sb.id_we_i & (sb.id_rd_i != 5'd0) &
                       ~stall & ~sb.flush_i;
    slot0_next.rd    = slot0_next.valid ? sb.id_rd_i : 5'd0;
  end

  // Slots advance one stage per cycle; stalled/flushed cycles insert a bubble.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      slots[0] <= slot0_next;
      for (int unsigned i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign sb.stall_o       = stall;
  assign sb.pc_we_o       = ~stall;
  assign sb.ifid_we_o     = ~stall;
  assign sb.idex_bubble_o = stall | sb.flush_i;
  assign sb.rf_we_o       = slots[DEPTH-1].valid;
  assign sb.rf_wr_o       = slots[DEPTH-1].valid ? slots[DEPTH-1].rd : 5'd0;
  assign sb.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-register pending-age model plus issue history,
// directed latency/priority/saturation scenarios and randomized traffic.
module tb_hazard_scoreboard;
  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.CNT_W(16)) sb ();
  hazard_scoreboard_if #(.CNT_W(4))  sb4 ();

  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(rst), .sb(sb));
  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .sb(sb4));

  logic       id_valid, rs1_used, rs2_used, id_we, flush;
  logic [4:0] rs1, rs2, id_rd;

  assign sb.id_valid_i     = id_valid;  assign sb4.id_valid_i     = id_valid;
  assign sb.id_rs1_i       = rs1;       assign sb4.id_rs1_i       = rs1;
  assign sb.id_rs2_i       = rs2;       assign sb4.id_rs2_i       = rs2;
  assign sb.id_rs1_used_i  = rs1_used;  assign sb4.id_rs1_used_i  = rs1_used;
  assign sb.id_rs2_used_i  = rs2_used;  assign sb4.id_rs2_used_i  = rs2_used;
  assign sb.id_rd_i        = id_rd;     assign sb4.id_rd_i        = id_rd;
  assign sb.id_we_i        = id_we;     assign sb4.id_we_i        = id_we;
  assign sb.flush_i        = flush;     assign sb4.flush_i        = flush;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: cycles until each register's writer leaves WB, and who issued in each past cycle.
  int         pend [32];
  logic [5:0] hist [$];
  int         stall_total;
  bit         cmp_en = 1'b0;

  function automatic void reset_model();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    hist.delete();
    for (int i = 0; i < int'(DEPTH); i++) hist.push_back(6'd0);
    stall_total = 0;
  endfunction

  function automatic bit exp_stall();
    bit h;
    h = 1'b0;
    if (rs1_used && rs1 != 5'd0 && pend[rs1] > 0) h = 1'b1;
    if (rs2_used && rs2 != 5'd0 && pend[rs2] > 0) h = 1'b1;
    return id_valid && h && !flush;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    bit st, iv;
    @(posedge clk);
    if (!rst) begin
      st = exp_stall();
      iv = id_valid && id_we && id_rd != 5'd0 && !st && !flush;
      for (int r = 0; r < 32; r++) if (pend[r] > 0) pend[r]--;
      if (iv) pend[id_rd] = DEPTH;
      hist.push_front({iv, iv ? id_rd : 5'd0});
      void'(hist.pop_back());
      if (st) stall_total++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      bit es;
      es = exp_stall();
      check("stall_o", int'(sb.stall_o), int'(es));
      check("pc_we_o", int'(sb.pc_we_o), int'(!es));
      check("ifid_we_o", int'(sb.ifid_we_o), int'(!es));
      check("idex_bubble_o", int'(sb.idex_bubble_o), int'(es || flush));
      check("rf_we_o", int'(sb.rf_we_o), int'(hist[DEPTH-1][5]));
      check("rf_wr_o", int'(sb.rf_wr_o), int'(hist[DEPTH-1][4:0]));
      check("stall_cnt_o", int'(sb.stall_cnt_o), sat(stall_total, 16));
      check("stall_cnt4", int'(sb4.stall_cnt_o), sat(stall_total, 4));
      check("stall4_o", int'(sb4.stall_o), int'(es));
    end
  end

  task automatic set_in(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit we, input bit fl);
    id_valid = v;  rs1 = 5'(r1);  rs1_used = u1;  rs2 = 5'(r2);  rs2_used = u2;
    id_rd = 5'(rd);  id_we = we;  flush = fl;
    #1;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (DEPTH + 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    nop();
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Hold the consumer in ID until it issues; returns stall cycles seen (bounded).
  task automatic run_consumer(output int n);
    n = 0;
    while (sb.stall_o && n < 10) begin
      n++;
      step();
    end
    step();
  endtask

  // Producer of x7, `gap` independent ops, then a consumer of x7.
  task automatic run_dist(input int gap, input int exp_n);
    int n;
    drain();
    set_in(1, 0, 1, 0, 0, 7, 1, 0); step();
    for (int g = 0; g < gap; g++) begin
      set_in(1, 20 + g, 1, 0, 0, 10 + g, 1, 0); step();
    end
    set_in(1, 7, 1, 1, 1, 8, 1, 0);
    run_consumer(n);
    check($sformatf("dist_gap%0d_stalls", gap), n, exp_n);
  endtask

  initial begin
    int n;
    reset_model();
    nop();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", int'(sb.stall_o), 0);
    check("rst_pc_we", int'(sb.pc_we_o), 1);
    check("rst_ifid_we", int'(sb.ifid_we_o), 1);
    check("rst_bubble", int'(sb.idex_bubble_o), 0);
    check("rst_rf_we", int'(sb.rf_we_o), 0);
    check("rst_rf_wr", int'(sb.rf_wr_o), 0);
    check("rst_cnt", int'(sb.stall_cnt_o), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // addi x5 ; add x6,x5,x1: three stalls, WB of x5 on the third.
    set_in(1, 0, 1, 0, 0, 5, 1, 0); step();
    set_in(1, 5, 1, 1, 1, 6, 1, 0);
    n = 0;
    while (sb.stall_o && n < 10) begin
      check("raw_bubble", int'(sb.idex_bubble_o), 1);
      if (n == 2) begin
        check("raw_wb_we", int'(sb.rf_we_o), 1);
        check("raw_wb_rd", int'(sb.rf_wr_o), 5);
      end
      n++;
      step();
    end
    check("raw_stalls", n, 3);
    check("raw_cnt", int'(sb.stall_cnt_o), 3);
    step();

    for (int g = 1; g <= 3; g++) run_dist(g, 3 - g);

    // x0 producer never tracked, never written back.
    drain();
    set_in(1, 0, 1, 0, 0, 0, 1, 0);
    step();
    set_in(1, 0, 1, 0, 1, 11, 0, 0);
    check("x0_stall", int'(sb.stall_o), 0);
    nop();
    for (int i = 0; i < 4; i++) begin
      check("x0_rf_we", int'(sb.rf_we_o), 0);
      step();
    end

    // lui x9 after a producer of x9 reads no sources.
    set_in(1, 0, 1, 0, 0, 9, 1, 0); step();
    set_in(1, 9, 0, 9, 0, 9, 1, 0);
    check("lui_stall", int'(sb.stall_o), 0);
    step();

    // Flush beats the hazard; the squashed rd=6 must not be tracked.
    drain();
    set_in(1, 0, 1, 0, 0, 5, 1, 0); step();
    set_in(1, 5, 1, 0, 0, 6, 1, 1);
    check("flush_stall", int'(sb.stall_o), 0);
    check("flush_pc_we", int'(sb.pc_we_o), 1);
    check("flush_bubble", int'(sb.idex_bubble_o), 1);
    step();
    set_in(1, 6, 1, 0, 0, 12, 0, 0);
    check("flush_slot0_invalid", int'(sb.stall_o), 0);
    step();

    // Asynchronous reset in the middle of a stall.
    drain();
    set_in(1, 0, 1, 0, 0, 5, 1, 0); step();
    set_in(1, 5, 1, 0, 0, 6, 1, 0);
    check("pre_rst_stall", int'(sb.stall_o), 1);
    step();
    #1;
    rst = 1'b1;
    reset_model();
    #1;
    check("mid_rst_stall", int'(sb.stall_o), 0);
    check("mid_rst_rf_we", int'(sb.rf_we_o), 0);
    check("mid_rst_cnt", int'(sb.stall_cnt_o), 0);
    check("mid_rst_pc_we", int'(sb.pc_we_o), 1);
    nop();
    step();
    rst = 1'b0;

    // Seven back-to-back RAW pairs: 21 stalls, 4-bit counter pinned at 15.
    for (int k = 0; k < 7; k++) begin
      set_in(1, 0, 1, 0, 0, 5, 1, 0); step();
      set_in(1, 0, 0, 5, 1, 6, 1, 0);
      run_consumer(n);
    end
    check("sat_cnt4", int'(sb4.stall_cnt_o), 15);
    check("sat_cnt16", int'(sb.stall_cnt_o), 21);

    // Randomized traffic over a small register range to provoke hazards.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step();
      if (c == 1500) do_reset();
    end

    nop();
    step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Stall controller for the decode stage of the 5-stage stall-only pipeline (IF/ID/EX/MEM/WB, no forwarding).
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Stalls ID while a source register it reads has a pending write.
- Drives PC/IF-ID write enables and ID/EX bubble insertion, and issues register-file write-back controls from its WB slot.

Parameters:
- DEPTH, 3: number of tracked in-flight slots; slot 0 = EX, slot DEPTH-1 = WB.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID holds a real (non-bubble) instruction.
- id_rs1_i  in  5  ID source register 1 (inst[19:15]).
- id_rs2_i  in  5  ID source register 2 (inst[24:20]).
- id_rs1_used_i  in  1  instruction reads rs1.
- id_rs2_used_i  in  1  instruction reads rs2.
- id_rd_i  in  5  ID destination (inst[11:7]).
- id_we_i  in  1  instruction writes rd.
- flush_i  in  1  taken branch/jump resolved in EX; squash IF and ID this cycle.
- stall_o  out  1  ID hazard stall (combinational).
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID register write enable.
- idex_bubble_o  out  1  load NOP into ID/EX this edge.
- rf_we_o  out  1  register-file write enable for the WB instruction.
- rf_wr_o  out  5  register-file write address for the WB instruction.
- stall_cnt_o  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Clock and reset: single clock clk_i. Reset reset_i is asynchronous and active-high.
- Reset state:
  - All slots invalid, rd=0.
  - stall_cnt_o=0.
  - Outputs settle to stall_o=0, pc_we_o=1, ifid_we_o=1, idex_bubble_o=0, rf_we_o=0, rf_wr_o=0.
  - Reset mid-stall drops all pending entries immediately.
- Slot state: each slot holds {valid, rd}. A slot is valid only if the instruction has we=1 and rd!=0, so x0 writes are never tracked.
- Hazard (combinational):
  - hit1 = id_rs1_used_i & rs1!=0 & any valid slot with rd==rs1.
  - hit2 is the same for rs2.
  - raw = id_valid_i & (hit1 | hit2).
  - ID's own rd is not compared with its own rs.
- Stall:
  - stall_o = raw & ~flush_i. Flush has priority because the ID instruction is being squashed.
  - pc_we_o = ifid_we_o = ~stall_o.
  - idex_bubble_o = stall_o | flush_i.
- Issue: at each posedge, slots shift toward WB (slot i <- slot i-1). Slot 0 is loaded as follows:
  - valid = id_valid_i & id_we_i & id_rd_i!=0 & ~stall_o & ~flush_i.
  - rd = id_rd_i if valid, else 0.
  - Stalled or flushed cycles therefore enter a bubble, matching idex_bubble_o.
- Write-back:
  - rf_we_o = slot[DEPTH-1].valid.
  - rf_wr_o = slot[DEPTH-1].rd when valid, else 0.
  - The register file writes at the posedge ending WB. ID sees the new value the next cycle, which is why the WB slot is included in the hazard compare.
- Latency: a consumer directly behind its producer stalls exactly DEPTH (3) cycles and issues on cycle 4. It stalls 2 cycles with one independent instruction between them, 1 with two, and 0 with three.
- Counter: stall_cnt_o increments on each posedge where stall_o=1 and saturates at all-ones (no wrap).
- Multiple matches (both sources, or several slots) give one stall, held until the last match retires.
- Matching is on register number only; the data value is irrelevant.

Test Plan:
- Reset: assert reset_i asynchronously mid-stall with slot EX rd=5 valid -> immediately stall_o=0, rf_we_o=0, stall_cnt_o=0, pc_we_o=1.
- Back-to-back RAW: issue addi x5 then add x6,x5,x1 -> stall_o=1 for exactly 3 cycles, idex_bubble_o=1 on those cycles, rf_we_o=1 with rf_wr_o=5 on the 3rd stall cycle, add issues on cycle 4, stall_cnt_o=3.
- Distance: producer x7 followed by two independent ops, then consumer of x7 -> 1 stall cycle; with three independent ops in between -> 0.
- x0 and unused sources: addi x0 then a consumer of x0 -> no stall and rf_we_o never 1. Producer x9 followed by lui x9 (rs unused) -> no stall.
- Flush priority: raw hazard present and flush_i=1 in the same cycle -> stall_o=0, pc_we_o=1, idex_bubble_o=1, slot 0 loaded invalid.
- Saturation: preload CNT_W=4 and force 20 stall cycles -> stall_cnt_o holds 4'hF.
